dct2_coeff_reorder: RTL

- Parametrised, registered successor to the DCT2 output permutation stage.
- Accepts one transform's butterfly partial outputs (E2, O2, O4, O8, ... packed flat) for N = 4..MAXN points.
- Reorders them into natural coefficient order and streams them out LANES coefficients per beat over a valid/ready interface.
- Sits between the 1-D DCT2 butterfly core and the transpose buffer.

---
 rtl/dct2_coeff_reorder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dct2_coeff_reorder.sv
// dct2_coeff_reorder: butterfly-order DCT2 outputs -> natural order, LANES per beat.
// Optional DCT2_REORDER_SHIFT_EN adds a rounding, saturating right shift at capture.
module dct2_coeff_reorder #(
  parameter int DW        = 16,
  parameter int MAX_LOG2N = 5,
  parameter int LANES     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_size,
  input  logic [(2**MAX_LOG2N)*DW-1:0]  in_data,
`ifdef DCT2_REORDER_SHIFT_EN
  input  logic [3:0]                    in_shift,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DW-1:0]           out_data,
  output logic                          out_first,
  output logic                          out_last,
  output logic [2:0]                    out_size,
  output logic                          size_err
);

  localparam int MAXN  = 2**MAX_LOG2N;
  localparam int MAXS  = MAX_LOG2N - 2;
  localparam int NBEAT = MAXN / LANES;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int BASE  = 4 / LANES;

  localparam logic [2:0] MAXS_C = 3'(MAXS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Butterfly slot feeding natural index k of an n-point transform.
  // k = 0 and k = n/2 land on E2[0], E2[1] (slots 0, 1).
  function automatic int slot_of(int n, int k);
    int t;
    int o;
    t = 0;
    o = k;
    if (k == 0 || k >= n) return 0;
    while (o % 2 == 0) begin
      o = o / 2;
      t++;
    end
    return ((n >> t) / 2) + (o - 1) / 2;
  endfunction

  logic [MAXS:0][MAXN*DW-1:0] perm;

  for (genvar gs = 0; gs <= MAXS; gs++) begin : g_size
    for (genvar gk = 0; gk < MAXN; gk++) begin : g_k
      localparam int NS = 4 << gs;
      localparam int SL = slot_of(NS, gk);
      if (gk < NS) begin : g_on
        assign perm[gs][gk*DW +: DW] = in_data[SL*DW +: DW];
      end else begin : g_off
        assign perm[gs][gk*DW +: DW] = '0;
      end
    end
  end

  logic               size_bad;
  logic [2:0]         size_eff;
  logic [MAXN*DW-1:0] reord;
  logic [MAXN*DW-1:0] cap_data;

  assign size_bad = in_size > MAXS_C;
  assign size_eff = size_bad ? MAXS_C : in_size;

  // Select the permutation for the clamped size.
  always_comb begin
    reord = '0;
    for (int s = 0; s <= MAXS; s++) begin
      if (size_eff == 3'(s)) reord = perm[s];
    end
  end

`ifdef DCT2_REORDER_SHIFT_EN
  function automatic logic [DW-1:0] rshift(
    input logic [DW-1:0] x,
    input logic [3:0]    sh
  );
    logic signed [DW:0] w;
    logic signed [DW:0] one;
    if (sh == 4'd0) return x;
    one = (DW+1)'(1);
    w   = $signed({x[DW-1], x});
    w   = w + (one <<< (sh - 4'd1));
    w   = w >>> sh;
    if (w[DW] != w[DW-1]) begin
      return w[DW] ? {1'b1, {(DW-1){1'b0}}}
                   : {1'b0, {(DW-1){1'b1}}};
    end
    return w[DW-1:0];
  endfunction

  // Round and saturate each coefficient on its way into the register.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < MAXN; k++) begin
      cap_data[k*DW +: DW] = rshift(reord[k*DW +: DW], in_shift);
    end
  end
`else
  assign cap_data = reord;
`endif

  logic [0:0]         state;
  logic [BW-1:0]      cnt;
  logic [BW-1:0]      cnt_last;
  logic [BW-1:0]      nb_m1;
  logic [MAXN*DW-1:0] coef;
  logic [2:0]         size_q;
  logic               serr_q;
  logic               cap;
  logic               fire;

  logic [NBEAT-1:0][LANES*DW-1:0] beats;

  assign nb_m1     = BW'((BASE << size_eff) - 1);
  assign beats     = coef;
  assign out_data  = beats[cnt];
  assign out_valid = (state == SEND);
  assign out_first = out_valid && (cnt == '0);
  assign out_last  = out_valid && (cnt == cnt_last);
  assign out_size  = size_q;
  assign size_err  = serr_q;

  // Reset gates in_ready so nothing is taken while rst_n is low.
  assign in_ready = rst_n &&
                    ((state == IDLE) || (out_last && out_ready));
  assign cap      = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // Capture reloads everything; otherwise walk beats on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cnt_last <= '0;
      coef     <= '0;
      size_q   <= '0;
      serr_q   <= 1'b0;
    end else begin
      serr_q <= cap && size_bad;
      if (cap) begin
        state    <= SEND;
        cnt      <= '0;
        cnt_last <= nb_m1;
        coef     <= cap_data;
        size_q   <= size_eff;
      end else if (fire) begin
        if (out_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
